// File: rtl/generatore_sequenza_pkg.sv
// ---------------------------------------------------------------------------
// generatore_sequenza_pkg
// Shared definitions for the serial pattern transmitter and for the blocks
// that consume its stream (recognisers, benches):
//   - stato_t     : FSM state encoding (IDLE, TX, DONE)
//   - PATTERN_DEF : default serial pattern, sent MSB first
//   - LEN_DEF     : default pattern length in bits
// ---------------------------------------------------------------------------
package generatore_sequenza_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TX   = 2'd1,
        S_DONE = 2'd2
    } stato_t;

    localparam int         LEN_DEF     = 7;
    localparam logic [6:0] PATTERN_DEF = 7'b0010110;

endpackage

// File: rtl/generatore_rc_uscita.sv
// ---------------------------------------------------------------------------
// generatore_rc_uscita
// Moore output network of the pattern transmitter: decodes {state, idx}
// into the serial line and its qualifiers. Purely combinational, driven by
// registers only, so no input of the top can reach an output directly.
// Ports:
//   stato  in  stato_t        current FSM state
//   idx    in  IDX_W          bit index inside the pattern (LEN-1 = first)
//   z      out 1              serial bit, 0 whenever v is low
//   v      out 1              z carries a valid pattern bit
//   busy   out 1              transmission in progress
//   done   out 1              one-cycle end-of-transfer marker
// ---------------------------------------------------------------------------
module generatore_rc_uscita
    import generatore_sequenza_pkg::*;
#(
    parameter int             LEN     = LEN_DEF,
    parameter logic [LEN-1:0] PATTERN = PATTERN_DEF,
    parameter int             IDX_W   = $clog2(LEN)
) (
    input  stato_t             stato,
    input  logic [IDX_W-1:0]   idx,
    output logic               z,
    output logic               v,
    output logic               busy,
    output logic               done
);

    always_comb begin
        z    = 1'b0;
        v    = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (stato)
            S_TX: begin
                z    = PATTERN[idx];
                v    = 1'b1;
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/generatore_sequenza.sv
// ---------------------------------------------------------------------------
// generatore_sequenza
// Moore serial pattern transmitter. On start it sends PATTERN (MSB first),
// one bit per clock, max(n_rep,1) times back-to-back, then raises done for
// one cycle and returns to IDLE.
// Ports:
//   clock   in  1      system clock, rising edge
//   reset_  in  1      asynchronous active-low reset
//   start   in  1      transfer request, honoured only in IDLE
//   n_rep   in  REP_W  repetition count, sampled with start (0 acts as 1)
//   z       out 1      serial data bit (0 when v is low)
//   v       out 1      z is a valid pattern bit
//   busy    out 1      transmission in progress
//   done    out 1      one-cycle pulse after the last bit
// ---------------------------------------------------------------------------
module generatore_sequenza
    import generatore_sequenza_pkg::*;
#(
    parameter int             LEN     = LEN_DEF,
    parameter logic [LEN-1:0] PATTERN = PATTERN_DEF,
    parameter int             REP_W   = 4
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             start,
    input  logic [REP_W-1:0] n_rep,
    output logic             z,
    output logic             v,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W    = $clog2(LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

    stato_t             stato, stato_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [REP_W-1:0]   rep_left, rep_left_next;

    // State and counter register; reset clears everything asynchronously so
    // the Moore outputs fall without waiting for an edge.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            stato    <= S_IDLE;
            idx      <= IDX_LAST;
            rep_left <= '0;
        end else begin
            stato    <= stato_next;
            idx      <= idx_next;
            rep_left <= rep_left_next;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        stato_next    = stato;
        idx_next      = idx;
        rep_left_next = rep_left;
        unique case (stato)
            S_IDLE: begin
                if (start) begin
                    stato_next = S_TX;
                    idx_next   = IDX_LAST;
                    // A request of 0 repetitions is served as a single one.
                    rep_left_next = (n_rep == '0) ? '0 : n_rep - 1'b1;
                end
            end
            S_TX: begin
                if (idx != '0) begin
                    idx_next = idx - 1'b1;
                end else if (rep_left != '0) begin
                    // Reload without a gap cycle between repetitions.
                    idx_next      = IDX_LAST;
                    rep_left_next = rep_left - 1'b1;
                end else begin
                    stato_next = S_DONE;
                end
            end
            S_DONE: begin
                stato_next = S_IDLE;
            end
            default: begin
                stato_next = S_IDLE;
            end
        endcase
    end

    generatore_rc_uscita #(
        .LEN     (LEN),
        .PATTERN (PATTERN),
        .IDX_W   (IDX_W)
    ) u_rc_uscita (
        .stato (stato),
        .idx   (idx),
        .z     (z),
        .v     (v),
        .busy  (busy),
        .done  (done)
    );

endmodule

// File: tb/tb_generatore_sequenza.sv
// ---------------------------------------------------------------------------
// tb_generatore_sequenza
// Self-checking bench for generatore_sequenza. A stream model holds the
// outputs expected for each upcoming cycle in a queue: an accepted request
// appends max(n_rep,1) copies of the pattern followed by a done cycle; an
// empty queue means the transmitter is idle and may accept a request.
// ---------------------------------------------------------------------------
module tb_generatore_sequenza;
    import generatore_sequenza_pkg::*;

    localparam int         LEN   = LEN_DEF;
    localparam logic [6:0] PAT   = PATTERN_DEF;
    localparam int         REP_W = 4;

    logic             clock;
    logic             reset_;
    logic             start;
    logic [REP_W-1:0] n_rep;
    logic             z, v, busy, done;

    int n_check;
    int n_fail;

    // Expected {z, v, busy, done} per future cycle.
    logic [3:0] exp_q[$];
    bit         cur_idle;
    int         cnt_v;
    int         cnt_done;

    generatore_sequenza #(
        .LEN     (LEN),
        .PATTERN (PAT),
        .REP_W   (REP_W)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .start  (start),
        .n_rep  (n_rep),
        .z      (z),
        .v      (v),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model,
    // then compare outputs 1 time unit after the edge. Ends on a negedge.
    task automatic tick(input string tag, input logic s, input logic [REP_W-1:0] n);
        logic [3:0] e;
        int         reps;
        start = s;
        n_rep = n;
        @(posedge clock);
        if (cur_idle && s) begin
            reps = (n == 0) ? 1 : int'(n);
            for (int r = 0; r < reps; r++)
                for (int b = LEN - 1; b >= 0; b--)
                    exp_q.push_back({PAT[b], 3'b110});
            exp_q.push_back(4'b0001);
        end
        if (exp_q.size() > 0) begin
            e        = exp_q.pop_front();
            cur_idle = 1'b0;
        end else begin
            e        = 4'b0000;
            cur_idle = 1'b1;
        end
        #1;
        verifica(tag, {28'd0, z, v, busy, done}, {28'd0, e});
        if (v) cnt_v++;
        if (done) cnt_done++;
        @(negedge clock);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 1'b0, 4'd0);
    endtask

    initial begin
        n_check  = 0;
        n_fail   = 0;
        cur_idle = 1'b1;
        cnt_v    = 0;
        cnt_done = 0;
        reset_   = 1'b0;
        start    = 1'b0;
        n_rep    = '0;

        // Reset state
        #1;
        verifica("reset_outputs", {28'd0, z, v, busy, done}, 32'd0);
        @(negedge clock);
        reset_ = 1'b1;
        idle_cycles("idle_after_reset", 2);

        // Single repetition: 7 bits, done, idle
        cnt_v = 0; cnt_done = 0;
        tick("rep1", 1'b1, 4'd1);
        idle_cycles("rep1", 9);
        verifica("rep1_nbits", cnt_v, 32'd7);
        verifica("rep1_ndone", cnt_done, 32'd1);

        // Three repetitions back-to-back
        cnt_v = 0; cnt_done = 0;
        tick("rep3", 1'b1, 4'd3);
        idle_cycles("rep3", 23);
        verifica("rep3_nbits", cnt_v, 32'd21);
        verifica("rep3_ndone", cnt_done, 32'd1);

        // Zero repetitions behaves as one
        cnt_v = 0; cnt_done = 0;
        tick("rep0", 1'b1, 4'd0);
        idle_cycles("rep0", 9);
        verifica("rep0_nbits", cnt_v, 32'd7);
        verifica("rep0_ndone", cnt_done, 32'd1);

        // Start held high: DONE plus one IDLE cycle between transfers
        cnt_v = 0; cnt_done = 0;
        for (int i = 0; i < 27; i++) tick("start_held", 1'b1, 4'd2);
        idle_cycles("start_held", 20);
        verifica("start_held_ndone", cnt_done, 32'd2);
        verifica("start_held_nbits", cnt_v, 32'd28);

        // Asynchronous reset during bit 4
        tick("areset", 1'b1, 4'd2);
        for (int i = 0; i < 3; i++) tick("areset", 1'b0, 4'd0);
        #2;
        reset_ = 1'b0;
        #1;
        verifica("areset_immediate", {28'd0, z, v, busy, done}, 32'd0);
        exp_q.delete();
        cur_idle = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        verifica("areset_held", {28'd0, z, v, busy, done}, 32'd0);
        @(negedge clock);
        reset_ = 1'b1;
        idle_cycles("after_areset", 3);
        cnt_v = 0;
        tick("after_areset", 1'b1, 4'd1);
        idle_cycles("after_areset", 9);
        verifica("after_areset_nbits", cnt_v, 32'd7);

        // Maximum request with n_rep scrambled mid-transfer
        cnt_v = 0; cnt_done = 0;
        tick("rep15", 1'b1, 4'd15);
        for (int i = 0; i < 108; i++)
            tick("rep15", 1'(($urandom % 3) == 0), 4'($urandom_range(0, 15)));
        verifica("rep15_nbits", cnt_v, 32'd105);
        verifica("rep15_ndone", cnt_done, 32'd1);
        idle_cycles("rep15_tail", 2);

        // Randomized traffic against the stream model
        for (int i = 0; i < 600; i++)
            tick("random", 1'(($urandom % 5) == 0), 4'($urandom_range(0, 6)));
        idle_cycles("random_tail", 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
